// File: rtl/rx_sample_buf.sv
// Double-banked I/Q sample buffer: packs each strobed sample into three 16-bit words,
// publishes full banks via rdy/buf_ack, flags overruns. Optional bank header: RX_BUF_SEQ_EN.
module rx_sample_buf #(
  parameter int WIDTH  = 24,
  parameter int NSAMPS = 170,
  parameter int AW     = 10
) (
  input  logic             adc_clk,
  input  logic             reset,
  input  logic             in_strobe,
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] in_q,
  input  logic             buf_ack,
  input  logic             ovfl_clr,
  input  logic [AW-1:0]    rd_addr,
  output logic [15:0]      rd_data,
  output logic             rdy,
  output logic             rdy_bank,
  output logic             ovfl,
  output logic [7:0]       ovfl_cnt
);

`ifdef RX_BUF_SEQ_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int DEPTH = 3 * NSAMPS + HDR;
  localparam int IW    = $clog2(NSAMPS + 1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  // Handshake: a bank is offered while rdy=1; buf_ack with rdy=1 releases it on the next edge.
  typedef enum logic [2:0] {S_IDLE, S_WI, S_WQ, S_WX, S_END} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  lat_i, lat_q;
  logic [IW-1:0]     idx;
  logic [AW-1:0]     wptr;
  logic              wr_bank;
  logic              last_samp;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [15:0]       wr_data;
  logic              drop, publish, overrun, ovfl_evt;
  logic [15:0]       mem [0:2*(2**AW)-1];
`ifdef RX_BUF_SEQ_EN
  logic [15:0]       seq;
`endif

  assign last_samp = (idx == IW'(NSAMPS - 1));

  always_ff @(posedge adc_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_strobe) state_nxt = S_WI;
      S_WI:    state_nxt = S_WQ;
      S_WQ:    state_nxt = S_WX;
      S_WX:    state_nxt = last_samp ? S_END : S_IDLE;
      S_END:   state_nxt = in_strobe ? S_WI : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wptr;
    wr_data = 16'h0000;
    publish = 1'b0;
    overrun = 1'b0;
    drop    = in_strobe && (state == S_WI || state == S_WQ || state == S_WX);
    case (state)
      S_WI: begin
        wr_en   = 1'b1;
        wr_data = lat_i[15:0];
      end
      S_WQ: begin
        wr_en   = 1'b1;
        wr_data = lat_q[15:0];
      end
      S_WX: begin
        wr_en   = 1'b1;
        wr_data = {lat_i[WIDTH-1 -: 8], lat_q[WIDTH-1 -: 8]};
      end
      S_END: begin
        // An ack landing in this cycle frees the ready slot before the completing bank claims it.
        publish = !rdy || buf_ack;
        overrun = !publish;
`ifdef RX_BUF_SEQ_EN
        wr_en   = publish;
        wr_addr = '0;
        wr_data = seq;
`endif
      end
      default: ;
    endcase
  end

  assign ovfl_evt = drop || overrun;

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      idx      <= '0;
      wptr     <= AW'(HDR);
      wr_bank  <= 1'b0;
      rdy      <= 1'b0;
      rdy_bank <= 1'b0;
      ovfl     <= 1'b0;
      ovfl_cnt <= 8'd0;
`ifdef RX_BUF_SEQ_EN
      seq      <= 16'h0000;
`endif
    end else begin
      if ((state == S_IDLE || state == S_END) && in_strobe) begin
        lat_i <= in_i;
        lat_q <= in_q;
      end
      if (state == S_WI || state == S_WQ || state == S_WX) wptr <= wptr + 1'b1;
      if (state == S_WX) idx <= idx + 1'b1;
      if (state == S_END) begin
        idx  <= '0;
        wptr <= AW'(HDR);
        if (publish) wr_bank <= ~wr_bank;
      end
      if (publish) begin
        rdy      <= 1'b1;
        rdy_bank <= wr_bank;
`ifdef RX_BUF_SEQ_EN
        seq      <= seq + 16'd1;
`endif
      end else if (buf_ack) begin
        rdy <= 1'b0;
      end
      // A new event outranks a same-cycle clear, so the count restarts at one.
      if (ovfl_evt) begin
        ovfl <= 1'b1;
        if (ovfl_clr)                ovfl_cnt <= 8'd1;
        else if (ovfl_cnt != 8'hFF)  ovfl_cnt <= ovfl_cnt + 8'd1;
      end else if (ovfl_clr) begin
        ovfl     <= 1'b0;
        ovfl_cnt <= 8'd0;
      end
    end
  end

  always_ff @(posedge adc_clk) begin
    if (wr_en && !reset) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  always_ff @(posedge adc_clk) begin
    if (reset)                         rd_data <= 16'h0000;
    else if ({1'b0, rd_addr} < DEPTH_W) rd_data <= mem[{rdy_bank, rd_addr}];
    else                               rd_data <= 16'h0000;
  end

endmodule

// File: tb/tb_rx_sample_buf.sv
// Bench for rx_sample_buf with NSAMPS=2: packing table, overrun, drop, ack-in-END,
// reset mid-sample, saturation, and bank sequence words when RX_BUF_SEQ_EN is defined.
module tb_rx_sample_buf;
  localparam int WIDTH  = 24;
  localparam int NSAMPS = 2;
  localparam int AW     = 10;
`ifdef RX_BUF_SEQ_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif

  logic             adc_clk;
  logic             reset;
  logic             in_strobe;
  logic [WIDTH-1:0] in_i, in_q;
  logic             buf_ack, ovfl_clr;
  logic [AW-1:0]    rd_addr;
  logic [15:0]      rd_data;
  logic             rdy, rdy_bank, ovfl;
  logic [7:0]       ovfl_cnt;

  rx_sample_buf #(.WIDTH(WIDTH), .NSAMPS(NSAMPS), .AW(AW)) dut (
    .adc_clk(adc_clk), .reset(reset), .in_strobe(in_strobe), .in_i(in_i), .in_q(in_q),
    .buf_ack(buf_ack), .ovfl_clr(ovfl_clr), .rd_addr(rd_addr), .rd_data(rd_data),
    .rdy(rdy), .rdy_bank(rdy_bank), .ovfl(ovfl), .ovfl_cnt(ovfl_cnt)
  );

  // clock / reset
  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] i;
    logic [23:0] q;
    logic [15:0] w0, w1, w2;
  } vec_t;

  vec_t        vecs [4];
  logic [15:0] exp_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        rdy_pre;
  logic [23:0] s [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b1; in_strobe = 1'b0; buf_ack = 1'b0; ovfl_clr = 1'b0; rd_addr = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic send_sample(input logic [23:0] i, input logic [23:0] q, input int gap);
    in_i = i; in_q = q; in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    repeat (gap - 1) tick();
  endtask

  // Second strobe is followed by W_I, W_Q, W_X; ack (if any) is held during the END cycle.
  task automatic fill_bank(input logic [23:0] i0, q0, i1, q1, input logic ack_end);
    send_sample(i0, q0, 8);
    in_i = i1; in_q = q1; in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    tick(); tick(); tick();
    rdy_pre = rdy;
    buf_ack = ack_end;
    tick();
    buf_ack = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic ack();
    buf_ack = 1'b1;
    tick();
    buf_ack = 1'b0;
  endtask

  task automatic push_sample(input logic [23:0] i, input logic [23:0] q);
    exp_q.push_back(i[15:0]);
    exp_q.push_back(q[15:0]);
    exp_q.push_back({i[23:16], q[23:16]});
  endtask

  // scoreboard: one expected word popped per read cycle
  task automatic read_words(input string name, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      rd_addr = AW'(base + k);
      tick();
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL %s: expected queue empty at addr %0d", name, base + k);
      end else begin
        check(name, {16'h0, rd_data}, {16'h0, exp_q.pop_front()});
      end
    end
  endtask

  initial begin
    vecs[0] = '{i: 24'h123456, q: 24'hABCDEF, w0: 16'h3456, w1: 16'hCDEF, w2: 16'h12AB};
    vecs[1] = '{i: 24'h000001, q: 24'hFFFFFF, w0: 16'h0001, w1: 16'hFFFF, w2: 16'h00FF};
    vecs[2] = '{i: 24'h800000, q: 24'h7FFFFF, w0: 16'h0000, w1: 16'hFFFF, w2: 16'h807F};
    vecs[3] = '{i: 24'hA5A5A5, q: 24'h5A5A5A, w0: 16'hA5A5, w1: 16'h5A5A, w2: 16'hA55A};
    in_i = '0; in_q = '0;
    do_reset();

    check("reset_rd_data", {16'h0, rd_data}, 32'h0);
    check("reset_rdy", {31'h0, rdy}, 32'h0);
    check("reset_rdy_bank", {31'h0, rdy_bank}, 32'h0);
    check("reset_ovfl", {31'h0, ovfl}, 32'h0);
    check("reset_ovfl_cnt", {24'h0, ovfl_cnt}, 32'h0);

    // packing table: two banks of two vectors each
    for (int b = 0; b < 2; b++) begin
      fill_bank(vecs[2*b].i, vecs[2*b].q, vecs[2*b+1].i, vecs[2*b+1].q, 1'b0);
      check("pack_rdy_before_end", {31'h0, rdy_pre}, 32'h0);
      check("pack_rdy", {31'h0, rdy}, 32'h1);
      check("pack_rdy_bank", {31'h0, rdy_bank}, b);
      for (int v = 2*b; v < 2*b + 2; v++) begin
        exp_q.push_back(vecs[v].w0);
        exp_q.push_back(vecs[v].w1);
        exp_q.push_back(vecs[v].w2);
      end
      read_words("pack_word", HB, 6);
`ifdef RX_BUF_SEQ_EN
      exp_q.push_back(16'(b));
      read_words("pack_seq", 0, 1);
`endif
      exp_q.push_back(16'h0000);
      read_words("beyond_depth", HB + 6, 1);
      exp_q.push_back(16'h0000);
      read_words("top_addr", 1023, 1);
      ack();
      check("pack_ack_clears_rdy", {31'h0, rdy}, 32'h0);
    end
    check("pack_no_ovfl", {31'h0, ovfl}, 32'h0);
    ack();
    check("ack_idle_ignored", {31'h0, rdy}, 32'h0);

    // overrun
    do_reset();
    for (int k = 0; k < 8; k++) s[k] = 24'($urandom_range(0, 24'hFFFFFF));
    fill_bank(s[0], s[1], s[2], s[3], 1'b0);
    check("ovr_first_rdy", {31'h0, rdy}, 32'h1);
    fill_bank(s[4], s[5], s[6], s[7], 1'b0);
    check("ovr_rdy", {31'h0, rdy}, 32'h1);
    check("ovr_rdy_bank", {31'h0, rdy_bank}, 32'h0);
    check("ovr_ovfl", {31'h0, ovfl}, 32'h1);
    check("ovr_cnt", {24'h0, ovfl_cnt}, 32'h1);
    push_sample(s[0], s[1]); push_sample(s[2], s[3]);
    read_words("ovr_bank0_intact", HB, 6);
    ack();
    fill_bank(s[6], s[7], s[4], s[5], 1'b0);
    check("ovr_after_ack_bank", {31'h0, rdy_bank}, 32'h1);
    push_sample(s[6], s[7]); push_sample(s[4], s[5]);
    read_words("ovr_bank1_data", HB, 6);
`ifdef RX_BUF_SEQ_EN
    exp_q.push_back(16'd1);
    read_words("ovr_seq_contig", 0, 1);
`endif
    ack();
    fill_bank(s[1], s[3], s[5], s[7], 1'b0);
    check("ovr_third_bank", {31'h0, rdy_bank}, 32'h0);
    push_sample(s[1], s[3]); push_sample(s[5], s[7]);
    read_words("ovr_bank0_refill", HB, 6);
`ifdef RX_BUF_SEQ_EN
    exp_q.push_back(16'd2);
    read_words("seq_third", 0, 1);
`endif
    ovfl_clr = 1'b1; tick(); ovfl_clr = 1'b0;
    check("clr_ovfl", {31'h0, ovfl}, 32'h0);
    check("clr_cnt", {24'h0, ovfl_cnt}, 32'h0);

    // drop: strobes at t, t+2 (dropped), t+4 (accepted)
    do_reset();
    for (int k = 0; k < 3; k++) s[k] = 24'($urandom_range(0, 24'hFFFFFF));
    in_i = s[0]; in_q = s[1]; in_strobe = 1'b1; tick();
    in_strobe = 1'b0; tick();
    in_i = s[2]; in_q = s[0]; in_strobe = 1'b1; tick();
    in_strobe = 1'b0;
    check("drop_ovfl", {31'h0, ovfl}, 32'h1);
    check("drop_cnt", {24'h0, ovfl_cnt}, 32'h1);
    tick();
    in_i = s[1]; in_q = s[2]; in_strobe = 1'b1; tick();
    in_strobe = 1'b0;
    repeat (7) tick();
    check("drop_t4_accepted_cnt", {24'h0, ovfl_cnt}, 32'h1);
    check("drop_rdy", {31'h0, rdy}, 32'h1);
    push_sample(s[0], s[1]); push_sample(s[1], s[2]);
    read_words("drop_words", HB, 6);

    // clear coinciding with a drop
    in_strobe = 1'b1; tick();
    in_strobe = 1'b0; tick();
    in_strobe = 1'b1; ovfl_clr = 1'b1; tick();
    in_strobe = 1'b0; ovfl_clr = 1'b0;
    check("clr_evt_ovfl", {31'h0, ovfl}, 32'h1);
    check("clr_evt_cnt", {24'h0, ovfl_cnt}, 32'h1);

    // ack during END of bank 1 while bank 0 is ready
    do_reset();
    for (int k = 0; k < 8; k++) s[k] = 24'($urandom_range(0, 24'hFFFFFF));
    fill_bank(s[0], s[1], s[2], s[3], 1'b0);
    fill_bank(s[4], s[5], s[6], s[7], 1'b1);
    check("sim_rdy", {31'h0, rdy}, 32'h1);
    check("sim_rdy_bank", {31'h0, rdy_bank}, 32'h1);
    check("sim_ovfl", {31'h0, ovfl}, 32'h0);
    push_sample(s[4], s[5]); push_sample(s[6], s[7]);
    read_words("sim_words", HB, 6);

    // reset after W_Q of the second sample
    do_reset();
    for (int k = 0; k < 8; k++) s[k] = 24'($urandom_range(0, 24'hFFFFFF));
    fill_bank(s[0], s[1], s[2], s[3], 1'b0);
    ack();
    in_strobe = 1'b1; tick(); in_strobe = 1'b0;
    fill_bank(s[4], s[5], s[6], s[7], 1'b0);
    check("rst_pre_bank", {31'h0, rdy_bank}, 32'h1);
    rd_addr = AW'(HB);
    send_sample(s[1], s[2], 8);
    in_i = s[3]; in_q = s[4]; in_strobe = 1'b1; tick();
    in_strobe = 1'b0; tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_rd_data", {16'h0, rd_data}, 32'h0);
    check("rst_rdy", {31'h0, rdy}, 32'h0);
    check("rst_rdy_bank", {31'h0, rdy_bank}, 32'h0);
    check("rst_ovfl", {31'h0, ovfl}, 32'h0);
    check("rst_cnt", {24'h0, ovfl_cnt}, 32'h0);
    fill_bank(s[5], s[6], s[7], s[0], 1'b0);
    check("rst_refill_rdy", {31'h0, rdy}, 32'h1);
    check("rst_refill_bank", {31'h0, rdy_bank}, 32'h0);
    push_sample(s[5], s[6]); push_sample(s[7], s[0]);
    read_words("rst_refill_words", HB, 6);
`ifdef RX_BUF_SEQ_EN
    exp_q.push_back(16'd0);
    read_words("rst_seq_restart", 0, 1);
`endif

    // saturation: continuous strobe drops three of every four
    do_reset();
    for (int k = 0; k < 400; k++) begin
      in_i = 24'($urandom_range(0, 24'hFFFFFF));
      in_q = 24'($urandom_range(0, 24'hFFFFFF));
      in_strobe = 1'b1;
      tick();
    end
    in_strobe = 1'b0;
    repeat (6) tick();
    check("sat_ovfl", {31'h0, ovfl}, 32'h1);
    check("sat_cnt", {24'h0, ovfl_cnt}, 32'hFF);
    ovfl_clr = 1'b1; tick(); ovfl_clr = 1'b0;
    check("sat_clr_cnt", {24'h0, ovfl_cnt}, 32'h0);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
